// File: rtl/pintar_pkg.sv
// Shared encodings for the matrix painter: menu FSM states seen on the
// state input and the painter's own scan FSM states.
package pintar_pkg;

  // Menu FSM state encodings driven by the game/menu controller.
  typedef enum logic [2:0] {
    Inicio      = 3'b000,
    Seleccion1  = 3'b001,
    Seleccion2  = 3'b010,
    Seleccion3  = 3'b011,
    Seleccion4  = 3'b100,
    GanarJuego  = 3'b101,
    PerderJuego = 3'b110,
    Juego       = 3'b111
  } estado_menu_e;

  // Painter scan FSM.
  typedef enum logic [1:0] {
    StArranque = 2'b00,
    StCarga    = 2'b01,
    StBarrido  = 2'b10
  } pintar_fsm_e;

endpackage

// File: rtl/pintar_divisor_barrido.sv
// Row prescaler: counts 0..DIV_BARRIDO-1 while enabled and flags the
// terminal count so the scanner knows when to move to the next row.
module pintar_divisor_barrido #(
  parameter int unsigned DIV_BARRIDO = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CuentaW = (DIV_BARRIDO > 1) ? $clog2(DIV_BARRIDO) : 1;
  localparam logic [CuentaW-1:0] Terminal = CuentaW'(DIV_BARRIDO - 1);

  logic [CuentaW-1:0] cuenta_q, cuenta_d;

  // Terminal-count flag only while the scanner is actually counting.
  always_comb begin
    tick_o = en_i && (cuenta_q == Terminal);
  end

  // Next count: synchronous clear wins, wrap to zero on terminal count.
  always_comb begin
    cuenta_d = cuenta_q;
    if (clr_i) begin
      cuenta_d = '0;
    end else if (en_i) begin
      cuenta_d = tick_o ? '0 : cuenta_q + CuentaW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

endmodule

// File: rtl/pintar_matriz_barrido.sv
// Row-scanned matrix painter. Composes playfield and menu pattern, takes a
// snapshot once per frame into a shadow buffer and multiplexes it row by
// row. Optional win/lose blinking is enabled by defining PINTAR_PARPADEO_EN.
module pintar_matriz_barrido
  import pintar_pkg::*;
#(
  parameter int unsigned FILAS            = 8,
  parameter int unsigned COLUMNAS         = 8,
  parameter int unsigned DATAWIDTH_ESTADO = 3,
  parameter int unsigned DIV_BARRIDO      = 50000,
  parameter int unsigned FRAMES_PARPADEO  = 32
) (
  input  logic                          PINTAR_CLOCK_50,
  input  logic                          PINTAR_RESET_InLow,
  input  logic [FILAS*COLUMNAS-1:0]     PINTAR_JUEGO_IN,
  input  logic [FILAS*COLUMNAS-1:0]     PINTAR_PATRON_IN,
  input  logic [DATAWIDTH_ESTADO-1:0]   PINTAR_ESTADO_IN,
  output logic [FILAS-1:0]              PINTAR_FILA_OUT,
  output logic [COLUMNAS-1:0]           PINTAR_COLUMNA_OUT,
  output logic                          PINTAR_INICIO_FRAME_OUT
);

  localparam int unsigned FilaW   = $clog2(FILAS);
  localparam int unsigned Pixeles = FILAS * COLUMNAS;
  localparam logic [FilaW-1:0] UltimaFila = FilaW'(FILAS - 1);

  if (FILAS < 2 || COLUMNAS < 1 || DIV_BARRIDO < 1 || FRAMES_PARPADEO < 1) begin : g_param_check
    $error("pintar_matriz_barrido: parameter out of range");
  end

  pintar_fsm_e         fsm_q, fsm_d;
  logic [FilaW-1:0]    fila_idx_q, fila_idx_d;
  logic [Pixeles-1:0]  sombra_q, sombra_d;
  logic [FILAS-1:0]    fila_q, fila_d;
  logic [COLUMNAS-1:0] columna_q, columna_d;
  logic                inicio_q, inicio_d;
  logic [Pixeles-1:0]  imagen;
  logic                tick;
  logic                apagar;

  // Playfield only shows while actually playing; every other state is pattern only.
  always_comb begin
    imagen = PINTAR_PATRON_IN;
    if (PINTAR_ESTADO_IN == DATAWIDTH_ESTADO'(Juego)) begin
      imagen = PINTAR_JUEGO_IN | PINTAR_PATRON_IN;
    end
  end

  pintar_divisor_barrido #(
    .DIV_BARRIDO (DIV_BARRIDO)
  ) u_divisor (
    .clk_i  (PINTAR_CLOCK_50),
    .rst_ni (PINTAR_RESET_InLow),
    .clr_i  (fsm_q == StCarga),
    .en_i   (fsm_q == StBarrido),
    .tick_o (tick)
  );

`ifdef PINTAR_PARPADEO_EN
  localparam int unsigned CuentaW = $clog2(2 * FRAMES_PARPADEO);

  logic [DATAWIDTH_ESTADO-1:0] estado_lat_q, estado_lat_d;
  logic [CuentaW-1:0]          frames_q, frames_d;

  // Frame counter restarts whenever the latched menu state changes, so each
  // win/lose screen always begins with its visible half.
  always_comb begin
    estado_lat_d = estado_lat_q;
    frames_d     = frames_q;
    if (fsm_q == StCarga) begin
      estado_lat_d = PINTAR_ESTADO_IN;
      if (PINTAR_ESTADO_IN != estado_lat_q) begin
        frames_d = '0;
      end else if (frames_q == CuentaW'(2 * FRAMES_PARPADEO - 1)) begin
        frames_d = '0;
      end else begin
        frames_d = frames_q + CuentaW'(1);
      end
    end
  end

  // Blank columns during the second half-period of a win/lose screen.
  always_comb begin
    apagar = ((estado_lat_q == DATAWIDTH_ESTADO'(GanarJuego)) ||
              (estado_lat_q == DATAWIDTH_ESTADO'(PerderJuego))) &&
             (frames_q >= CuentaW'(FRAMES_PARPADEO));
  end

  // Blink state registers.
  always_ff @(posedge PINTAR_CLOCK_50 or negedge PINTAR_RESET_InLow) begin
    if (!PINTAR_RESET_InLow) begin
      estado_lat_q <= '0;
      frames_q     <= '0;
    end else begin
      estado_lat_q <= estado_lat_d;
      frames_q     <= frames_d;
    end
  end
`else
  assign apagar = 1'b0;
`endif

  // Scan FSM next state and registered-output next values.
  always_comb begin
    fsm_d      = fsm_q;
    fila_idx_d = fila_idx_q;
    sombra_d   = sombra_q;
    fila_d     = '0;
    columna_d  = '0;
    inicio_d   = 1'b0;
    unique case (fsm_q)
      StArranque: begin
        fsm_d = StCarga;
      end
      StCarga: begin
        sombra_d   = imagen;
        fila_idx_d = '0;
        inicio_d   = 1'b1;
        fsm_d      = StBarrido;
      end
      StBarrido: begin
        fila_d[fila_idx_q] = 1'b1;
        if (!apagar) begin
          columna_d = sombra_q[fila_idx_q*COLUMNAS +: COLUMNAS];
        end
        if (tick) begin
          if (fila_idx_q == UltimaFila) begin
            fsm_d = StCarga;
          end else begin
            fila_idx_d = fila_idx_q + FilaW'(1);
          end
        end
      end
      default: begin
        fsm_d = StArranque;
      end
    endcase
  end

  // State, shadow buffer and output registers.
  always_ff @(posedge PINTAR_CLOCK_50 or negedge PINTAR_RESET_InLow) begin
    if (!PINTAR_RESET_InLow) begin
      fsm_q      <= StArranque;
      fila_idx_q <= '0;
      sombra_q   <= '0;
      fila_q     <= '0;
      columna_q  <= '0;
      inicio_q   <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      fila_idx_q <= fila_idx_d;
      sombra_q   <= sombra_d;
      fila_q     <= fila_d;
      columna_q  <= columna_d;
      inicio_q   <= inicio_d;
    end
  end

  assign PINTAR_FILA_OUT         = fila_q;
  assign PINTAR_COLUMNA_OUT      = columna_q;
  assign PINTAR_INICIO_FRAME_OUT = inicio_q;

endmodule

// File: tb/tb_pintar_matriz_barrido.sv
// Bench for pintar_matriz_barrido: two instances (DIV_BARRIDO 4 and 1) share
// the inputs and are checked every cycle against a frame-level model.
module tb_pintar_matriz_barrido;

  localparam int NumFp = 2;  // FRAMES_PARPADEO

  logic        clk;
  logic        rst_n;
  logic [63:0] juego;
  logic [63:0] patron;
  logic [2:0]  estado;
  logic [7:0]  fila0, col0, fila1, col1;
  logic        ini0, ini1;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;  // rising edges since reset release

  logic [63:0] img_m [2];
  logic [2:0]  est_m [2];
  int          run_m [2];

  pintar_matriz_barrido #(
    .FILAS(8), .COLUMNAS(8), .DATAWIDTH_ESTADO(3), .DIV_BARRIDO(4), .FRAMES_PARPADEO(NumFp)
  ) dut0 (
    .PINTAR_CLOCK_50         (clk),
    .PINTAR_RESET_InLow      (rst_n),
    .PINTAR_JUEGO_IN         (juego),
    .PINTAR_PATRON_IN        (patron),
    .PINTAR_ESTADO_IN        (estado),
    .PINTAR_FILA_OUT         (fila0),
    .PINTAR_COLUMNA_OUT      (col0),
    .PINTAR_INICIO_FRAME_OUT (ini0)
  );

  pintar_matriz_barrido #(
    .FILAS(8), .COLUMNAS(8), .DATAWIDTH_ESTADO(3), .DIV_BARRIDO(1), .FRAMES_PARPADEO(NumFp)
  ) dut1 (
    .PINTAR_CLOCK_50         (clk),
    .PINTAR_RESET_InLow      (rst_n),
    .PINTAR_JUEGO_IN         (juego),
    .PINTAR_PATRON_IN        (patron),
    .PINTAR_ESTADO_IN        (estado),
    .PINTAR_FILA_OUT         (fila1),
    .PINTAR_COLUMNA_OUT      (col1),
    .PINTAR_INICIO_FRAME_OUT (ini1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_fila0"}, 64'(fila0), 64'd0);
    check({tag, "_col0"},  64'(col0),  64'd0);
    check({tag, "_ini0"},  64'(ini0),  64'd0);
    check({tag, "_fila1"}, 64'(fila1), 64'd0);
    check({tag, "_col1"},  64'(col1),  64'd0);
    check({tag, "_ini1"},  64'(ini1),  64'd0);
  endtask

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < 2; i++) begin
      img_m[i] = '0;
      est_m[i] = 3'b000;
      run_m[i] = 0;
    end
  endtask

  // Row shown after edge nn for a given row period, -1 when blank.
  function automatic int fila_modelo(input int nn, input int d);
    int k;
    if (nn < 2) return -1;
    k = (nn - 2) % (1 + 8 * d);
    if (k == 0) return -1;
    return (k - 1) / d;
  endfunction

  // One clock edge, then compare both instances with the frame model.
  task automatic tick();
    logic [7:0] ef, ec, of_, oc;
    logic       ei, oi;
    int         d, k, r;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      check_blank($sformatf("in_reset"));
    end else begin
      n++;
      for (int i = 0; i < 2; i++) begin
        d  = (i == 0) ? 4 : 1;
        ef = '0;
        ec = '0;
        ei = 1'b0;
        if (n >= 2) begin
          k = (n - 2) % (1 + 8 * d);
          if (k == 0) begin
            img_m[i] = (estado == 3'b111) ? (juego | patron) : patron;
            if (estado != est_m[i]) run_m[i] = 0;
            else run_m[i] = (run_m[i] + 1) % (2 * NumFp);
            est_m[i] = estado;
            ei = 1'b1;
          end else begin
            r  = (k - 1) / d;
            ef = 8'(1 << r);
            ec = img_m[i][r*8 +: 8];
`ifdef PINTAR_PARPADEO_EN
            if ((est_m[i] == 3'b101 || est_m[i] == 3'b110) && run_m[i] >= NumFp) ec = '0;
`endif
          end
        end
        of_ = (i == 0) ? fila0 : fila1;
        oc  = (i == 0) ? col0 : col1;
        oi  = (i == 0) ? ini0 : ini1;
        check($sformatf("d%0d_fila n=%0d", i, n), 64'(of_), 64'(ef));
        check($sformatf("d%0d_col n=%0d", i, n), 64'(oc), 64'(ec));
        check($sformatf("d%0d_ini n=%0d", i, n), 64'(oi), 64'(ei));
      end
    end
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) tick();
  endtask

  task automatic esperar_fila(input int r);
    bit hit = 1'b0;
    for (int g = 0; g < 200 && !hit; g++) begin
      if (fila_modelo(n, 4) == r) hit = 1'b1;
      else tick();
    end
    vectors++;
    assert (hit === 1'b1) else begin
      miscompares++;
      $error("FAIL wait_row%0d observed=timeout expected=row_reached", r);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    estado = 3'b111;
    juego  = 64'h01;
    patron = 64'h80;
    model_reset();
    run(2);
    rst_n = 1'b1;

    // Playing: row 0 shows 8'h81, two full frames.
    run(70);

    // Menu: playfield hidden, only pattern row 3.
    estado = 3'b000;
    juego  = '1;
    patron = 64'h3C << 24;
    run(70);

    // Pattern changes mid-frame must not tear the frame in progress.
    esperar_fila(4);
    patron = {$urandom, $urandom};
    run(40);

    // Play then win screen: blink behaviour.
    estado = 3'b111;
    patron = {$urandom, $urandom};
    run(70);
    estado = 3'b101;
    patron = '1;
    run(6 * 33);
    estado = 3'b110;
    run(5 * 33);

    // Asynchronous reset during row 5.
    esperar_fila(5);
    #2;
    rst_n = 1'b0;
    #1;
    check_blank("async_reset");
    model_reset();
    run(2);
    rst_n = 1'b1;
    run(70);

    // Random inputs held for random lengths.
    for (int t = 0; t < 25; t++) begin
      juego  = {$urandom, $urandom};
      patron = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) estado = 3'($urandom_range(0, 7));
      run($urandom_range(1, 60));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
